// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM states and special-case result constants for mdu_iter
package mdu_pkg;
  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam logic [63:0] ONES = '1;
  function automatic logic [63:0] most_neg(input int w);
    return 64'd1 << (w - 1);
  endfunction
endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one restoring-division iteration, shifting the next dividend bit into the remainder
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH+1:0] sh;
  logic [WIDTH+1:0] diff;
  // trial subtract; restore when it goes negative
  always_comb begin
    sh = {rem, quo[WIDTH-1]};
    diff = sh - {2'b00, dvs};
    rem_o = diff[WIDTH+1] ? sh[WIDTH:0] : diff[WIDTH:0];
    quo_o = {quo[WIDTH-2:0], ~diff[WIDTH+1]};
  end
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit; define MDU_FAST_MUL_EN for single-step multiplies
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ALL1 = WIDTH'(ONES);
  localparam logic [WIDTH-1:0] MNEG = WIDTH'(most_neg(WIDTH));
  state_t state, state_d;
  logic acc, take, fast, na, nb, spec_in, b_zero, ovf;
  logic [WIDTH-1:0] ma_in, mb_in, spec_val;
  logic [2:0] f3;
  logic sa, sb, spec;
  logic [WIDTH-1:0] ma, mb, spec_res, quo, quo_n, quo_c, rem_c, res_d;
  logic [CW-1:0] cnt;
  logic [W2-1:0] p, prod, prod_c;
  logic [WIDTH:0] rem, rem_n, sum;
  assign take = state == IDLE && start && !acc;
  assign busy = acc || state != IDLE;
  assign done = state == DONE;
`ifdef MDU_FAST_MUL_EN
  assign fast = !f3[2];
  assign prod = W2'(ma) * W2'(mb);
`else
  assign fast = 1'b0;
  assign prod = p;
`endif
  // operand decode at accept: signedness, magnitudes and special-case detection
  always_comb begin
    na = (funct3 == F_MULH || funct3 == F_MULHSU || funct3 == F_DIV || funct3 == F_REM) && op_a[WIDTH-1];
    nb = (funct3 == F_MULH || funct3 == F_DIV || funct3 == F_REM) && op_b[WIDTH-1];
    ma_in = na ? -op_a : op_a;
    mb_in = nb ? -op_b : op_b;
    b_zero = op_b == '0;
    ovf = (funct3 == F_DIV || funct3 == F_REM) && op_a == MNEG && op_b == ALL1;
    spec_in = funct3[2] && (b_zero || ovf);
    spec_val = b_zero ? (funct3[1] ? op_a : ALL1) : (funct3[1] ? '0 : op_a);
  end
  // next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = acc ? ((spec || fast) ? DONE : CALC) : IDLE;
      CALC: state_d = cnt == CW'(WIDTH - 1) ? FIX : CALC;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // shift-add step and sign correction / half selection for the final result
  always_comb begin
    sum = {1'b0, p[W2-1:WIDTH]} + (p[0] ? {1'b0, ma} : '0);
    prod_c = (sa ^ sb) ? -prod : prod;
    quo_c = (sa ^ sb) ? -quo : quo;
    rem_c = sa ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    res_d = spec ? spec_res : f3[2] ? (f3[1] ? rem_c : quo_c) : (f3[1:0] == 2'b00 ? prod_c[WIDTH-1:0] : prod_c[W2-1:WIDTH]);
  end
  mdu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem(rem),
    .quo(quo),
    .dvs(mb),
    .rem_o(rem_n),
    .quo_o(quo_n)
  );
  // state register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else state <= state_d;
  end
  // operand capture, iteration datapath and result register
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc <= 1'b0;
      cnt <= '0;
      result <= '0;
    end else begin
      acc <= take;
      if (take) begin
        f3 <= funct3;
        sa <= na;
        sb <= nb;
        ma <= ma_in;
        mb <= mb_in;
        spec <= spec_in;
        spec_res <= spec_val;
        cnt <= '0;
        p <= {{WIDTH{1'b0}}, mb_in};
        rem <= '0;
        quo <= ma_in;
      end
      if (state == CALC) begin
        cnt <= cnt + 1'b1;
        p <= {sum, p[WIDTH-1:1]};
        rem <= rem_n;
        quo <= quo_n;
      end
      if (state_d == DONE && state != DONE) result <= res_d;
    end
  end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed and randomized checks of mdu_iter against a 64-bit arithmetic reference
module tb_mdu_iter;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic start = 1'b0;
  logic [2:0] funct3 = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic busy, done;
  logic [31:0] result;
  int vectors = 0;
  int miscompares = 0;
  localparam logic [31:0] MNEG = 32'h8000_0000;

  mdu_iter #(.WIDTH(32)) dut (
    .CLK(CLK),
    .RST(RST),
    .start(start),
    .funct3(funct3),
    .op_a(op_a),
    .op_b(op_b),
    .busy(busy),
    .done(done),
    .result(result)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, pr;
    logic [63:0] ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: begin up = ua * ub; return up[31:0]; end
      3'd1: begin pr = sa * sb; return pr[63:32]; end
      3'd2: begin pr = sa * longint'(ub); return pr[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MNEG && b == 32'hFFFF_FFFF) return a;
        pr = sa / sb; return pr[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MNEG && b == 32'hFFFF_FFFF) return 32'd0;
        pr = sa % sb; return pr[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || ((f == 3'd4 || f == 3'd6) && a == MNEG && b == 32'hFFFF_FFFF))) return 1;
`ifdef MDU_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 34;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    start = 1'b1;
    funct3 = f;
    op_a = a;
    op_b = b;
    @(posedge CLK);
    #1;
    start = 1'b0;
    funct3 = 3'($urandom);
    op_a = $urandom;
    op_b = $urandom;
    chk("busy_at_accept", 32'(busy), 32'd1);
  endtask

  task automatic finish_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int elapsed);
    int n, busy_n, exp_lat;
    logic [31:0] exp;
    exp = ref_mdu(f, a, b);
    exp_lat = ref_lat(f, a, b);
    n = elapsed;
    busy_n = elapsed + 1;
    while (!done && n < 100) begin
      @(posedge CLK);
      #1;
      n++;
      if (busy) busy_n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat + 1));
    chk({tag, "_result"}, result, exp);
    @(posedge CLK);
    #1;
    chk({tag, "_done_pulse"}, {30'd0, busy, done}, 32'd0);
    chk({tag, "_result_hold"}, result, exp);
  endtask

  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    accept(f, a, b);
    finish_op(tag, f, a, b, 0);
  endtask

  initial begin
    logic [2:0] f;
    logic [31:0] a, b;
    logic seen;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_state", {busy, done, result}, 34'd0);
    RST = 1'b0;
    run("mul_neg", 3'd0, 32'd7, 32'hFFFF_FFFD);
    run("mulh_mneg", 3'd1, 32'h8000_0000, 32'h8000_0000);
    run("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("mulhsu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2);
    run("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2);
    run("divu", 3'd5, 32'd100, 32'd7);
    run("remu", 3'd7, 32'd100, 32'd7);
    run("div_by0", 3'd4, 32'd5, 32'd0);
    run("remu_by0", 3'd7, 32'd5, 32'd0);
    run("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("rem_ovf_value", result, 32'd0);
    accept(3'd5, 32'd1000, 32'd9);
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    start = 1'b1;
    funct3 = 3'd0;
    op_a = 32'd3;
    op_b = 32'd3;
    @(negedge CLK);
    start = 1'b0;
    finish_op("ignore_start", 3'd5, 32'd1000, 32'd9, 7);
    accept(3'd0, 32'd1234, 32'd5678);
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("abort_state", {busy, done, result}, 34'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge CLK);
      #1;
      seen |= done | busy;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run("mul_after_rst", 3'd0, 32'd3, 32'd4);
    chk("mul_after_rst_value", result, 32'd12);
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = MNEG; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run($sformatf("rand%0d_f%0d", i, f), f, a, b);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
